// File: rtl/dac_serial_rx.sv
`timescale 1ns/1ps
// dac_serial_rx: chip-side receiver for the three-wire DAC programming link.
// The serial inputs are oversampled on clk and frames (LSB first) are
// recovered: start 0, ADDR_W-bit address, DAC_W-bit level, stop 1.
// Each accepted frame updates one register of the DAC level bank.
// Build option: define DAC_RX_TIMEOUT_EN to abort frames whose serial clock
// stalls for TIMEOUT_CYC clk cycles mid-frame.
module dac_serial_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DAC     = 8,
  parameter int ADDR_W      = 3,
  parameter int DAC_W       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ser_clk,
  input  logic                       ser_rst_n,
  input  logic                       ser_data,
  output logic [NUM_DAC*DAC_W-1:0]   dac_level,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DAC_W-1:0]           wr_data,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int MAXF_W = (ADDR_W > DAC_W) ? ADDR_W : DAC_W;
  localparam int CNT_W  = $clog2(MAXF_W + 1);

  // Reject parameter sets the frame format cannot support.
  generate
    if (SYNC_STAGES < 2 || NUM_DAC != (1 << ADDR_W) || TIMEOUT_CYC < 1) begin : g_param_check
      $error("dac_serial_rx: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADDR, LEVEL, STOP} state_t;

  logic [SYNC_STAGES-1:0]     sclk_sync_q, srst_sync_q, sdat_sync_q;
  logic                       sclk_prev_q;
  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DAC_W-1:0]           lvl_q, lvl_d;
  logic [NUM_DAC*DAC_W-1:0]   bank_q, bank_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [DAC_W-1:0]           wr_data_q, wr_data_d;
  logic                       wr_valid_q, wr_valid_d;
  logic                       frame_err_q, frame_err_d;
  logic                       sclk_s, link_rst_n, sample, fall;

`ifdef DAC_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]           tmo_q, tmo_d;
`endif

  // Bring the asynchronous link wires into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      srst_sync_q <= '0;
      sdat_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ser_clk};
      srst_sync_q <= {srst_sync_q[SYNC_STAGES-2:0], ser_rst_n};
      sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], ser_data};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign link_rst_n = srst_sync_q[SYNC_STAGES-1];
  assign sample     = sdat_sync_q[SYNC_STAGES-1];
  // Falling serial clock marks mid-bit: the transmitter moved data on the rise.
  assign fall       = sclk_prev_q & ~sclk_s;

  // Frame state, shift registers, level bank and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      lvl_q       <= '0;
      bank_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef DAC_RX_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      lvl_q       <= lvl_d;
      bank_q      <= bank_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
`ifdef DAC_RX_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Next state: link reset wins over a sample; a sample wins over a timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    lvl_d       = lvl_q;
    bank_d      = bank_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef DAC_RX_TIMEOUT_EN
    tmo_d       = (state_q == IDLE) ? '0 : tmo_q + 1'b1;
`endif
    if (!link_rst_n) begin
      // Link reset silently drops any frame in flight and clears the bank.
      state_d   = IDLE;
      cnt_d     = '0;
      bank_d    = '0;
      wr_addr_d = '0;
      wr_data_d = '0;
`ifdef DAC_RX_TIMEOUT_EN
      tmo_d     = '0;
`endif
    end else if (fall) begin
`ifdef DAC_RX_TIMEOUT_EN
      tmo_d = '0;
`endif
      case (state_q)
        IDLE: begin
          if (!sample) begin
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          // LSB first: shift in at the top so bit 0 ends up at the bottom.
          addr_d = (addr_q >> 1) | (ADDR_W'(sample) << (ADDR_W - 1));
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            state_d = LEVEL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LEVEL: begin
          lvl_d = (lvl_q >> 1) | (DAC_W'(sample) << (DAC_W - 1));
          if (cnt_q == CNT_W'(DAC_W - 1)) begin
            state_d = STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          // A 0 here is a framing error, never a new start bit.
          if (sample) begin
            bank_d[int'(addr_q)*DAC_W +: DAC_W] = lvl_q;
            wr_addr_d  = addr_q;
            wr_data_d  = lvl_q;
            wr_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
`ifdef DAC_RX_TIMEOUT_EN
    end else if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYC)) begin
      state_d     = IDLE;
      cnt_d       = '0;
      frame_err_d = 1'b1;
      tmo_d       = '0;
`endif
    end
  end

  assign dac_level = bank_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/dac_serial_rx.md
Name: dac_serial_rx

Overview:
- Receiving end of the three-wire DAC programming link (serial reset, serial clock, serial data) that the FPGA-side controller drives toward the chip.
- Oversamples the link on the local system clock, recovers frames, and maintains a bank of DAC level registers.
- Sits in the chip-side model and loopback bench, and in the FPGA as a link monitor.
- Frame, LSB first: start bit 0, 3-bit DAC address, 8-bit level, then idle/stop bit 1.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on each serial input (min 2).
- NUM_DAC, 8: number of level registers; equals 2**ADDR_W.
- ADDR_W, 3: address field width.
- DAC_W, 8: level field width.
- TIMEOUT_CYC, 65535: clk cycles without a serial clock falling edge, mid-frame, before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ser_clk  in  1  serial link clock, asynchronous to clk
- ser_rst_n  in  1  serial link reset, active low, asynchronous to clk
- ser_data  in  1  serial link data, asynchronous to clk
- dac_level  out  NUM_DAC*DAC_W  flattened level bank; DAC n at [n*DAC_W +: DAC_W]
- wr_valid  out  1  one-cycle pulse per accepted frame
- wr_addr  out  ADDR_W  address of the last accepted frame
- wr_data  out  DAC_W  level of the last accepted frame
- frame_err  out  1  one-cycle pulse per rejected or aborted frame
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: rst high at a clk edge sets all outputs to 0, FSM to IDLE, bit counter and shift register to 0.
- Synchronization: ser_clk, ser_rst_n and ser_data each pass through SYNC_STAGES flops.
- Edge detect: one extra register on synced ser_clk; a falling edge is synced value 0 with previous value 1.
- Sampling point: ser_data is sampled only on detected ser_clk falling edges (mid-bit). The transmitter changes data on rising edges. The sample is the synced ser_data value in the edge-detect cycle.
- Link reset: while synced ser_rst_n = 0:
  - FSM forced to IDLE.
  - All dac_level bytes, wr_addr and wr_data cleared to 0.
  - Samples ignored; no wr_valid or frame_err.
  - If the FSM was not IDLE when ser_rst_n fell, a mid-frame abort raises no frame_err.
- FSM states:
  - IDLE: sample 0 -> ADDR, bit counter = 0. Sample 1 -> stay (idle ones are legal and unbounded).
  - ADDR: shift sample into addr[count]; after ADDR_W samples -> LEVEL, counter = 0.
  - LEVEL: shift sample into level[count]; after DAC_W samples -> STOP.
  - STOP, sample 1: write level into dac_level[addr], latch wr_addr/wr_data, pulse wr_valid, -> IDLE.
  - STOP, sample 0: pulse frame_err, no register change, -> IDLE. This 0 is not taken as a start bit; the next start needs a later 0 seen in IDLE.
- Throughput: back-to-back frames with exactly one idle bit between them (stop bit then next start bit) are supported with no loss.
- Output timing:
  - wr_valid and frame_err are high for exactly one clk cycle, the cycle after the clk edge that processes the stop sample.
  - dac_level, wr_addr and wr_data show new values in that same cycle and hold until the next accepted frame or a reset.
- Latency: stop-bit ser_clk falling edge at the pin -> wr_valid high within SYNC_STAGES+2 clk cycles.
- Rewrite: writing the same address again overwrites that register. Other registers are unchanged.
- Simultaneous events: rst has priority over ser_rst_n; ser_rst_n has priority over a sample in the same cycle.
- Minimum rate: ser_clk high and low phases must each be at least SYNC_STAGES+1 clk cycles. Faster links are out of spec; behaviour is undefined but must not lock up once rst is applied.

Optional Feature:
- Macro: DAC_RX_TIMEOUT_EN.
- Defined:
  - A counter clears on every detected ser_clk falling edge and increments while busy.
  - When it reaches TIMEOUT_CYC: FSM -> IDLE, frame_err pulses once, no register write.
  - Counter is held at 0 in IDLE.
- Not defined: no counter logic; a stalled link leaves busy high until the link resumes, ser_rst_n goes low, or rst.

Test Plan:
- Reset: rst high 4 cycles, ser_rst_n=1, ser_data=1, ser_clk period 40 clk -> all outputs 0, busy 0; 20 idle ones give no pulse.
- Single write: start, addr 5 (bits 1,0,1), level 0xA3 (LSB first), stop 1 -> one wr_valid; wr_addr=5, wr_data=0xA3; dac_level[47:40]=0xA3; all other bytes 0.
- Repeat stream: frames addr 0 lvl 0x01, addr 7 lvl 0xFF, addr 0 lvl 0x5A, each separated by a single idle bit -> 3 wr_valid pulses; final byte0=0x5A, byte7=0xFF.
- Bad stop: frame addr 2 lvl 0x3C with stop bit 0 -> one frame_err, no wr_valid, byte2 stays 0. The following good frame addr 2 lvl 0x3C is accepted.
- Link reset mid-frame: after byte3=0x77 is written, drop ser_rst_n during LEVEL bit 4 for 3 ser_clk periods -> busy 0, all bytes 0, no frame_err. The next full frame is accepted.
- Timeout (DAC_RX_TIMEOUT_EN, TIMEOUT_CYC=200): stop ser_clk after addr bits -> exactly one frame_err about 200 cycles after the last edge; busy 0; no write.
